// File: rtl/multi_digit_timer.sv
// multi_digit_timer: keypad-loaded BCD countdown timer (MM..:SS) with pause/cancel and
// an optional add-30-seconds button.
//
// Optional feature macro: TIMER_ADD30_EN enables the add-30-seconds logic. When it is
// undefined the add30 port is present but has no effect.
//
// Parameters
//   MIN_DIGITS : number of BCD minute digits (1..4)
//   TICK_DIV   : enabled clock cycles per one-second tick (1..65535)
// Ports
//   clock    : clock, all state changes on its rising edge
//   clrn     : asynchronous active-low reset
//   data     : keypad BCD digit (values above 9 stored as 9)
//   loadn    : active-low digit-entry strobe, one digit per cycle (IDLE/PAUSED only)
//   en       : tick prescaler enable
//   start    : start / resume request (level)
//   pause    : pause when running, cancel (clear to 0) otherwise
//   add30    : add 30 seconds (only with TIMER_ADD30_EN)
//   sec_ones : seconds ones digit
//   sec_tens : seconds tens digit
//   mins     : minute digits, least significant digit in bits [3:0]
//   zero     : combinational, high when all digits are 0
//   running  : high in RUN
//   done     : one-cycle pulse after the countdown reaches zero
module multi_digit_timer #(
  parameter int unsigned MIN_DIGITS = 2,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic                    clock,
  input  logic                    clrn,
  input  logic [3:0]              data,
  input  logic                    loadn,
  input  logic                    en,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    add30,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    running,
  output logic                    done
);

  localparam int unsigned MW = 4 * MIN_DIGITS;

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e        state_q, state_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic [MW-1:0] mins_q, mins_d;
  logic [15:0]   presc_q, presc_d;

  logic          tick;
  logic [15:0]   presc_nxt;
  logic [3:0]    data_sat;
  logic [3:0]    dec_ones, dec_tens;
  logic [MW-1:0] dec_mins;
  logic          dec_zero;

  // BCD decrement with borrow rippling up through zero digits.
  function automatic logic [MW-1:0] mins_dec(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          borrow;
    r      = m;
    borrow = 1'b1;
    for (int unsigned i = 0; i < MIN_DIGITS; i++) begin
      if (borrow) begin
        if (m[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = m[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  assign tick      = (state_q == StRun) && en && (presc_q == 16'(TICK_DIV - 1));
  assign presc_nxt = tick ? 16'd0 : presc_q + 16'd1;
  assign data_sat  = (data > 4'd9) ? 4'd9 : data;

  // One-second decrement; tens values 6..9 from the keypad count down unchanged.
  always_comb begin
    dec_ones = ones_q;
    dec_tens = tens_q;
    dec_mins = mins_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else if (tens_q != 4'd0) begin
      dec_tens = tens_q - 4'd1;
      dec_ones = 4'd9;
    end else begin
      dec_mins = mins_dec(mins_q);
      dec_tens = 4'd5;
      dec_ones = 4'd9;
    end
  end

  assign dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_mins == '0);

`ifdef TIMER_ADD30_EN
  // BCD increment; bit MW is the carry out of the top digit.
  function automatic logic [MW:0] mins_inc(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          carry;
    r     = m;
    carry = 1'b1;
    for (int unsigned i = 0; i < MIN_DIGITS; i++) begin
      if (carry) begin
        if (m[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = m[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return {carry, r};
  endfunction

  logic [3:0]    add_ones, add_tens;
  logic [MW-1:0] add_mins;
  logic [MW:0]   add_inc;

  always_comb begin
    add_inc  = mins_inc(mins_q);
    add_ones = ones_q;
    add_tens = tens_q;
    add_mins = mins_q;
    if (tens_q <= 4'd2) begin
      add_tens = tens_q + 4'd3;
    end else if (add_inc[MW]) begin
      // Minute overflow saturates to the largest displayable time.
      add_mins = {MIN_DIGITS{4'd9}};
      add_tens = 4'd5;
      add_ones = 4'd9;
    end else begin
      add_tens = tens_q - 4'd3;
      add_mins = add_inc[MW-1:0];
    end
  end
`else
  logic unused_add30;
  assign unused_add30 = add30;
`endif

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      mins_q  <= '0;
      presc_q <= 16'd0;
    end else begin
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      mins_q  <= mins_d;
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: terminal decrement > pause > start > add30 > entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    mins_d  = mins_q;
    presc_d = presc_q;
    unique case (state_q)
      StRun: begin
        if (tick && dec_zero) begin
          // Reaching zero wins even over a simultaneous pause.
          state_d = StDone;
          ones_d  = dec_ones;
          tens_d  = dec_tens;
          mins_d  = dec_mins;
          presc_d = 16'd0;
        end else if (pause) begin
          // Digits and prescaler count are held.
          state_d = StPaused;
`ifdef TIMER_ADD30_EN
        end else if (add30) begin
          ones_d = add_ones;
          tens_d = add_tens;
          mins_d = add_mins;
          if (en) presc_d = presc_nxt;
`endif
        end else begin
          if (en) presc_d = presc_nxt;
          if (tick) begin
            ones_d = dec_ones;
            tens_d = dec_tens;
            mins_d = dec_mins;
          end
        end
      end
      StIdle, StPaused: begin
        if (pause) begin
          state_d = StIdle;
          ones_d  = 4'd0;
          tens_d  = 4'd0;
          mins_d  = '0;
          presc_d = 16'd0;
        end else if (start && !zero) begin
          state_d = StRun;
          // Resuming from PAUSED keeps the partial second.
          if (state_q == StIdle) presc_d = 16'd0;
`ifdef TIMER_ADD30_EN
        end else if (add30) begin
          ones_d = add_ones;
          tens_d = add_tens;
          mins_d = add_mins;
          if (state_q == StIdle) begin
            state_d = StRun;
            presc_d = 16'd0;
          end
`endif
        end else if (!loadn) begin
          ones_d = data_sat;
          tens_d = ones_q;
          mins_d = MW'({mins_q, tens_q});
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    running = (state_q == StRun);
    done    = (state_q == StDone);
  end

  assign sec_ones = ones_q;
  assign sec_tens = tens_q;
  assign mins     = mins_q;
  assign zero     = (ones_q == 4'd0) && (tens_q == 4'd0) && (mins_q == '0);

endmodule

// File: tb/tb_multi_digit_timer.sv
// Directed bench for multi_digit_timer: two instances (TICK_DIV=1 and TICK_DIV=4),
// both with two minute digits. Values are compared as {mins, sec_tens, sec_ones}.
module tb_multi_digit_timer;

  logic       clock = 1'b0;
  logic       clrn  = 1'b0;
  logic [3:0] data  = 4'd0;
  logic       loadn = 1'b1;
  logic       en    = 1'b1;
  logic       en4   = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       add30 = 1'b0;

  logic [3:0] sec_ones, sec_tens, sec_ones4, sec_tens4;
  logic [7:0] mins, mins4;
  logic       zero, running, done, zero4, running4, done4;
  logic [15:0] val, val4;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int d0;

  always #5 clock = ~clock;

  multi_digit_timer #(.MIN_DIGITS(2), .TICK_DIV(1)) dut (
    .clock(clock), .clrn(clrn), .data(data), .loadn(loadn), .en(en), .start(start),
    .pause(pause), .add30(add30), .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins),
    .zero(zero), .running(running), .done(done)
  );

  multi_digit_timer #(.MIN_DIGITS(2), .TICK_DIV(4)) dut4 (
    .clock(clock), .clrn(clrn), .data(data), .loadn(loadn), .en(en4), .start(start),
    .pause(pause), .add30(add30), .sec_ones(sec_ones4), .sec_tens(sec_tens4), .mins(mins4),
    .zero(zero4), .running(running4), .done(done4)
  );

  assign val  = {mins, sec_tens, sec_ones};
  assign val4 = {mins4, sec_tens4, sec_ones4};

  // done as seen during the cycle that just ended
  always @(posedge clock) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are read at the next falling edge.
  task automatic cycle();
    @(negedge clock);
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    cycle();
    clrn = 1'b1;
    cycle();
  endtask

  task automatic load_digit(input logic [3:0] d);
    data  = d;
    loadn = 1'b0;
    cycle();
    loadn = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_val", 32'(val), 32'h0000);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    cycle();
    clrn = 1'b1;
    cycle();

    // Entry 1,9,9 and saturation of a non-BCD key
    load_digit(4'd1);
    load_digit(4'd9);
    load_digit(4'd9);
    check("entry_val", 32'(val), 32'h0199);
    check("entry_idle", 32'(running), 32'd0);
    do_reset();
    load_digit(4'hC);
    check("entry_sat", 32'(val), 32'h0009);

    // start ignored while zero
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("start_zero_ign", 32'(running), 32'd0);

    // Countdown 1:00 -> 0:00
    load_digit(4'd1);
    load_digit(4'd0);
    load_digit(4'd0);
    d0    = done_cnt;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("cd_start_val", 32'(val), 32'h0100);
    check("cd_running", 32'(running), 32'd1);
    cycle();
    check("cd_first_tick", 32'(val), 32'h0059);
    repeat (58) cycle();
    check("cd_last_nonzero", 32'(val), 32'h0001);
    check("cd_no_early_done", 32'(done), 32'd0);
    cycle();
    check("cd_zero_val", 32'(val), 32'h0000);
    check("cd_done_pulse", 32'(done), 32'd1);
    check("cd_done_not_run", 32'(running), 32'd0);
    cycle();
    check("cd_done_cleared", 32'(done), 32'd0);
    check("cd_idle", 32'(running), 32'd0);
    check("cd_done_count", 32'(done_cnt - d0), 32'd1);

    // Pause / resume / cancel
    do_reset();
    load_digit(4'd3);
    load_digit(4'd0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    pause = 1'b1;
    cycle();
    pause = 1'b0;
    check("pause_hold_val", 32'(val), 32'h0030);
    check("pause_not_run", 32'(running), 32'd0);
    repeat (10) cycle();
    check("pause_held_10", 32'(val), 32'h0030);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("resume_run", 32'(running), 32'd1);
    check("resume_val", 32'(val), 32'h0030);
    cycle();
    check("resume_tick", 32'(val), 32'h0029);
    pause = 1'b1;
    cycle();
    check("pause2_val", 32'(val), 32'h0029);
    cycle();
    pause = 1'b0;
    check("cancel_val", 32'(val), 32'h0000);
    check("cancel_zero", 32'(zero), 32'd1);
    check("cancel_idle", 32'(running), 32'd0);

    // Prescaler on the TICK_DIV=4 instance, en toggling
    do_reset();
    en = 1'b0;
    load_digit(4'd1);
    load_digit(4'd0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("psc_run", 32'(running4), 32'd1);
    for (int i = 0; i < 6; i++) begin
      en4 = (i % 2 == 0);
      cycle();
    end
    check("psc_3_enabled", 32'(val4), 32'h0010);
    en4 = 1'b1;
    cycle();
    check("psc_4_enabled", 32'(val4), 32'h0009);
    for (int i = 0; i < 8; i++) begin
      en4 = (i % 2 == 1);
      cycle();
    end
    en4 = 1'b0;
    check("psc_8_enabled", 32'(val4), 32'h0008);
    en = 1'b1;

    // Reset mid-run: immediate clear, no done
    do_reset();
    load_digit(4'd2);
    load_digit(4'd1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    check("rr_pre_val", 32'(val), 32'h0020);
    d0   = done_cnt;
    #2 clrn = 1'b0;
    #1;
    check("rr_val_now", 32'(val), 32'h0000);
    check("rr_zero_now", 32'(zero), 32'd1);
    check("rr_running_now", 32'(running), 32'd0);
    cycle();
    cycle();
    clrn = 1'b1;
    repeat (3) cycle();
    check("rr_idle", 32'(running), 32'd0);
    check("rr_no_done", 32'(done_cnt - d0), 32'd0);

    // pause + start together in IDLE with a nonzero value: cancel wins
    load_digit(4'd5);
    check("ps_loaded", 32'(val), 32'h0005);
    pause = 1'b1;
    start = 1'b1;
    cycle();
    pause = 1'b0;
    start = 1'b0;
    check("ps_cleared", 32'(val), 32'h0000);
    check("ps_idle", 32'(running), 32'd0);

`ifdef TIMER_ADD30_EN
    do_reset();
    load_digit(4'd4);
    load_digit(4'd5);
    add30 = 1'b1;
    cycle();
    add30 = 1'b0;
    check("a30_carry_val", 32'(val), 32'h0115);
    check("a30_idle_run", 32'(running), 32'd1);
    pause = 1'b1;
    cycle();
    cycle();
    pause = 1'b0;
    load_digit(4'd9);
    load_digit(4'd9);
    load_digit(4'd5);
    load_digit(4'd9);
    check("a30_pre_sat", 32'(val), 32'h9959);
    add30 = 1'b1;
    cycle();
    add30 = 1'b0;
    check("a30_sat_val", 32'(val), 32'h9959);
    pause = 1'b1;
    cycle();
    cycle();
    pause = 1'b0;
    add30 = 1'b1;
    cycle();
    add30 = 1'b0;
    check("a30_zero_val", 32'(val), 32'h0030);
    check("a30_zero_run", 32'(running), 32'd1);
`else
    do_reset();
    load_digit(4'd4);
    load_digit(4'd5);
    add30 = 1'b1;
    cycle();
    add30 = 1'b0;
    check("a30_ignored_val", 32'(val), 32'h0045);
    check("a30_ignored_idle", 32'(running), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
